// File: rtl/fifo_sel_arb.sv
// N-channel bus arbiter: fixed-priority or round-robin, grant held per transfer,
// optional maximum hold time with forced hand-off to a waiting channel.
module fifo_sel_arb #(
    parameter int N_CH     = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 0,
    parameter int HOLD_W   = 8
) (
    input  logic             glb_clk,
    input  logic             glb_rst,
    input  logic             rr_mode,
    input  logic [N_CH-1:0]  req,
    output logic [N_CH-1:0]  grant,
    output logic             sel_valid,
    output logic [IDX_W-1:0] sel_idx,
    output logic             hold_expired
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  last_owner, last_nx;
    logic [HOLD_W-1:0] hold_cnt, cnt_nx;
    logic [N_CH-1:0]   grant_nx;
    logic [IDX_W-1:0]  idx_nx;
    logic              valid_nx;
    logic              hexp_nx;

    logic [N_CH-1:0]   cand;
    logic [IDX_W-1:0]  win;
    logic              win_found;
    int                pos;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [N_CH-1:0]   ONE       = N_CH'(1);

    // The owner is always excluded; when it has dropped req this equals req.
    assign cand = req & ~grant;

    always_comb begin
        win       = '0;
        win_found = 1'b0;
        pos       = 0;
        for (int k = 0; k < N_CH; k++) begin
            if (rr_mode)
                pos = (int'(last_owner) + 1 + k) % N_CH;
            else
                pos = k;
            if (!win_found && cand[pos]) begin
                win       = IDX_W'(pos);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        idx_nx   = sel_idx;
        valid_nx = sel_valid;
        hexp_nx  = 1'b0;
        cnt_nx   = hold_cnt;
        last_nx  = last_owner;
        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx = OWN;
                    grant_nx = ONE << win;
                    idx_nx   = win;
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                    last_nx  = win;
                end
            end
            OWN: begin
                if (|(req & grant)) begin
                    if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && win_found) begin
                        grant_nx = ONE << win;
                        idx_nx   = win;
                        hexp_nx  = 1'b1;
                        cnt_nx   = '0;
                        last_nx  = win;
                    end else if (MAX_HOLD != 0 && hold_cnt != HOLD_LAST) begin
                        cnt_nx = hold_cnt + 1'b1;
                    end
                end else if (win_found) begin
                    grant_nx = ONE << win;
                    idx_nx   = win;
                    cnt_nx   = '0;
                    last_nx  = win;
                end else begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    idx_nx   = '0;
                    valid_nx = 1'b0;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge glb_clk) begin
        if (glb_rst) begin
            state        <= IDLE;
            grant        <= '0;
            sel_idx      <= '0;
            sel_valid    <= 1'b0;
            hold_expired <= 1'b0;
            hold_cnt     <= '0;
            last_owner   <= IDX_W'(N_CH - 1);
        end else begin
            state        <= state_nx;
            grant        <= grant_nx;
            sel_idx      <= idx_nx;
            sel_valid    <= valid_nx;
            hold_expired <= hexp_nx;
            hold_cnt     <= cnt_nx;
            last_owner   <= last_nx;
        end
    end

endmodule

// File: tb/tb_fifo_sel_arb.sv
// Randomized bench for fifo_sel_arb: unlimited-hold and MAX_HOLD=4 instances
// share stimulus and are each compared every cycle with a reference model.
module tb_fifo_sel_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rr  = 1'b0;
    logic [3:0] req = 4'b0000;

    logic [3:0] gnt [2];
    logic       sv  [2];
    logic [1:0] si  [2];
    logic       he  [2];

    int errors = 0;
    int checks = 0;

    int MH     [2] = '{0, 4};
    int m_own  [2] = '{-1, -1};
    int m_cnt  [2] = '{0, 0};
    int m_last [2] = '{3, 3};
    bit m_hexp [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    fifo_sel_arb #(.N_CH(4), .IDX_W(2), .MAX_HOLD(0), .HOLD_W(8)) dut0 (
        .glb_clk(clk), .glb_rst(rst), .rr_mode(rr), .req(req),
        .grant(gnt[0]), .sel_valid(sv[0]), .sel_idx(si[0]),
        .hold_expired(he[0])
    );

    fifo_sel_arb #(.N_CH(4), .IDX_W(2), .MAX_HOLD(4), .HOLD_W(8)) dut4 (
        .glb_clk(clk), .glb_rst(rst), .rr_mode(rr), .req(req),
        .grant(gnt[1]), .sel_valid(sv[1]), .sel_idx(si[1]),
        .hold_expired(he[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] c, input bit rrm,
                                input int last);
        int i;
        for (int k = 1; k <= 4; k++) begin
            i = rrm ? (last + k) % 4 : k - 1;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            logic [3:0] others;
            int w;
            m_hexp[j] = 1'b0;
            if (rst) begin
                m_own[j]  = -1;
                m_cnt[j]  = 0;
                m_last[j] = 3;
            end else if (m_own[j] < 0) begin
                w = pick(req, rr, m_last[j]);
                if (w >= 0) begin
                    m_own[j] = w; m_cnt[j] = 0; m_last[j] = w;
                end
            end else begin
                others = req;
                others[m_own[j]] = 1'b0;
                w = pick(others, rr, m_last[j]);
                if (req[m_own[j]]) begin
                    if (MH[j] != 0 && m_cnt[j] == MH[j] - 1 && w >= 0) begin
                        m_own[j] = w; m_cnt[j] = 0; m_last[j] = w;
                        m_hexp[j] = 1'b1;
                    end else if (MH[j] != 0 && m_cnt[j] < MH[j] - 1) begin
                        m_cnt[j]++;
                    end
                end else if (w >= 0) begin
                    m_own[j] = w; m_cnt[j] = 0; m_last[j] = w;
                end else begin
                    m_own[j] = -1; m_cnt[j] = 0;
                end
            end
        end
    end

    task automatic check_all();
        logic [3:0] eg;
        for (int j = 0; j < 2; j++) begin
            eg = (m_own[j] < 0) ? 4'b0000 : 4'(1 << m_own[j]);
            chk($sformatf("grant_mh%0d", MH[j]), 32'(gnt[j]), 32'(eg));
            chk($sformatf("sel_valid_mh%0d", MH[j]), 32'(sv[j]), 32'(m_own[j] >= 0));
            chk($sformatf("sel_idx_mh%0d", MH[j]), 32'(si[j]),
                32'((m_own[j] < 0) ? 0 : m_own[j]));
            chk($sformatf("hold_expired_mh%0d", MH[j]), 32'(he[j]), 32'(m_hexp[j]));
        end
    endtask

    task automatic step(input logic r, input logic rm, input logic [3:0] q);
        @(negedge clk);
        check_all();
        rst = r;
        rr  = rm;
        req = q;
    endtask

    initial begin
        logic [3:0] q;
        logic       rm;
        logic [3:0] m;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b0, 4'b0000);
        repeat (5) step(1'b0, 1'b0, 4'b0000);
        repeat (2) step(1'b0, 1'b0, 4'b1010);
        repeat (3) step(1'b0, 1'b0, 4'b1011);
        repeat (3) step(1'b0, 1'b0, 4'b1001);
        repeat (2) step(1'b0, 1'b0, 4'b0000);
        repeat (5) begin
            step(1'b0, 1'b1, 4'b1111);
            m = (m_own[0] < 0) ? 4'b0000 : 4'(1 << m_own[0]);
            step(1'b0, 1'b1, 4'b1111 & ~m);
        end
        repeat (2) step(1'b0, 1'b0, 4'b0000);
        repeat (14) step(1'b0, 1'b0, 4'b1100);
        step(1'b0, 1'b0, 4'b0000);
        repeat (10) step(1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 4'b0000);
        repeat (3) step(1'b0, 1'b0, 4'b0100);
        step(1'b1, 1'b0, 4'b0100);
        repeat (3) step(1'b0, 1'b0, 4'b0100);
        q  = 4'b0000;
        rm = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) q[b] = ~q[b];
            if ($urandom_range(30) == 0) rm = ~rm;
            step(($urandom_range(200) == 0), rm, q);
        end
        @(negedge clk);
        check_all();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
